divider_seq: RTL and testbench



---
 rtl/divider_pkg.sv | 17 +
 rtl/divider_seq_step.sv | 23 ++
 rtl/divider_seq.sv | 147 ++++++++++++++
 tb/tb_divider_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package divider_pkg;

    localparam int unsigned DIV_WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } divider_state_t;

    // Iteration counter width: must hold WIDTH-1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/divider_seq_step.sv
// One restoring-division step: shift in a dividend bit, compare, subtract or restore.
module divider_seq_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next_c,
    output logic             q_bit_c
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // One extra bit so the shifted remainder can never wrap before the compare.
    always_comb begin
        shifted    = {rem, bit_in};
        diff       = shifted - {1'b0, divisor};
        q_bit_c    = (shifted >= {1'b0, divisor});
        rem_next_c = q_bit_c ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_seq.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIVIDER_SEQ_SIGNED_EN to add the signed_mode port (two's-complement, truncating).
module divider_seq
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
`ifdef DIVIDER_SEQ_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned   CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    divider_state_t   state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-2:0] quo;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;

`ifdef DIVIDER_SEQ_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic neg_q;
    logic neg_r;
`endif

    divider_seq_step #(.WIDTH(WIDTH)) u_step (
        .rem        (rem),
        .bit_in     (dvd[WIDTH-1]),
        .divisor    (dvs),
        .rem_next_c (rem_next),
        .q_bit_c    (q_bit)
    );

    assign q_fin = {quo, q_bit};

    // Operand magnitudes at accept and sign restoration of the final step.
    always_comb begin
        a_mag = dividend;
        b_mag = divisor;
        q_res = q_fin;
        r_res = rem_next;
`ifdef DIVIDER_SEQ_SIGNED_EN
        a_neg = signed_mode & dividend[WIDTH-1];
        b_neg = signed_mode & divisor[WIDTH-1];
        if (a_neg) a_mag = WIDTH'(0) - dividend;
        if (b_neg) b_mag = WIDTH'(0) - divisor;
        if (neg_q) q_res = WIDTH'(0) - q_fin;
        if (neg_r) r_res = WIDTH'(0) - rem_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            quo         <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIVIDER_SEQ_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        dvd      <= a_mag;
                        dvs      <= b_mag;
                        rem      <= '0;
                        quo      <= '0;
`ifdef DIVIDER_SEQ_SIGNED_EN
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
`endif
                        // Zero divisor short-circuits with the legacy all-ones result.
                        if (divisor == '0) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_LAST;
                        end
                    end
                end
                BUSY: begin
                    rem <= rem_next;
                    quo <= q_fin[WIDTH-2:0];
                    dvd <= {dvd[WIDTH-2:0], 1'b0};
                    if (cnt == '0) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        quotient    <= q_res;
                        remainder   <= r_res;
                        div_by_zero <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed cases plus random sweep at WIDTH 8 and 16.
// Signed cases are compiled in when DIVIDER_SEQ_SIGNED_EN is defined.
module tb_divider_seq;

    logic clk;
    logic rst_n;

    logic        v8, ir8, ov8, or8, z8, sm8;
    logic [7:0]  a8, b8, q8, r8;
    logic        v16, ir16, ov16, or16, z16, sm16;
    logic [15:0] a16, b16, q16, r16;

    int total;
    int bad;

    divider_seq #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (v8),
`ifdef DIVIDER_SEQ_SIGNED_EN
        .signed_mode (sm8),
`endif
        .in_ready    (ir8),
        .dividend    (a8),
        .divisor     (b8),
        .out_valid   (ov8),
        .out_ready   (or8),
        .quotient    (q8),
        .remainder   (r8),
        .div_by_zero (z8)
    );

    divider_seq #(.WIDTH(16)) dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (v16),
`ifdef DIVIDER_SEQ_SIGNED_EN
        .signed_mode (sm16),
`endif
        .in_ready    (ir16),
        .dividend    (a16),
        .divisor     (b16),
        .out_valid   (ov16),
        .out_ready   (or16),
        .quotient    (q16),
        .remainder   (r16),
        .div_by_zero (z16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cur_q(input int sel);
        return (sel == 8) ? 32'(q8) : 32'(q16);
    endfunction
    function automatic logic [31:0] cur_r(input int sel);
        return (sel == 8) ? 32'(r8) : 32'(r16);
    endfunction
    function automatic logic cur_z(input int sel);
        return (sel == 8) ? z8 : z16;
    endfunction
    function automatic logic cur_ov(input int sel);
        return (sel == 8) ? ov8 : ov16;
    endfunction
    function automatic logic cur_ir(input int sel);
        return (sel == 8) ? ir8 : ir16;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic sm);
        if (sel == 8) begin
            v8 = v; a8 = a[7:0]; b8 = b[7:0]; sm8 = sm;
        end else begin
            v16 = v; a16 = a[15:0]; b16 = b[15:0]; sm16 = sm;
        end
    endtask

    task automatic set_ready(input int sel, input logic rdy);
        if (sel == 8) or8 = rdy;
        else or16 = rdy;
    endtask

    // Reference: plain arithmetic on integers, truncating division when signed.
    task automatic ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                             input logic sm, output logic [31:0] q,
                             output logic [31:0] r, output logic z);
        logic [31:0] mask;
        int sa, sb, mn;
        mask = (32'd1 << w) - 32'd1;
        a = a & mask;
        b = b & mask;
        z = (b == 0);
        if (b == 0) begin
            q = mask;
            r = a;
        end else if (!sm) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = a[w-1] ? int'(a | ~mask) : int'(a);
            sb = b[w-1] ? int'(b | ~mask) : int'(b);
            mn = -(1 << (w - 1));
            if (sa == mn && sb == -1) begin
                q = a;
                r = 0;
            end else begin
                q = 32'(sa / sb) & mask;
                r = 32'(sa % sb) & mask;
            end
        end
    endtask

    // Issue one operation, check latency and result, then drain it with the chosen ready pattern.
    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic sm, input int hold, input bit rnd);
        logic [31:0] eq, er, mask;
        logic        ez, rdy;
        int          edges;
        mask = (32'd1 << sel) - 32'd1;
        ref_model(sel, a, b, sm, eq, er, ez);
        chk("in_ready_idle", 32'(cur_ir(sel)), 1);
        chk("out_valid_idle", 32'(cur_ov(sel)), 0);
        drive(sel, 1'b1, a, b, sm);
        @(negedge clk);
        edges = 1;
        while (cur_ov(sel) !== 1'b1 && edges < 4 * sel) begin
            chk("in_ready_busy", 32'(cur_ir(sel)), 0);
            drive(sel, 1'b1, $urandom, $urandom, 1'($urandom));
            set_ready(sel, rnd ? 1'($urandom) : 1'b0);
            @(negedge clk);
            edges++;
        end
        drive(sel, 1'b0, 0, 0, 1'b0);
        chk("latency", 32'(edges), ((b & mask) == 0) ? 32'd1 : 32'(sel + 1));
        chk("quotient", cur_q(sel), eq);
        chk("remainder", cur_r(sel), er);
        chk("div_by_zero", 32'(cur_z(sel)), 32'(ez));
        chk("ready_valid_excl", 32'(cur_ir(sel) & cur_ov(sel)), 0);
        for (int cyc = 0; cyc < 200; cyc++) begin
            rdy = (hold > 0) ? (cyc >= hold) : (rnd ? 1'($urandom) : 1'b1);
            set_ready(sel, rdy);
            drive(sel, 1'b1, $urandom, $urandom, 1'($urandom));
            @(negedge clk);
            if (rdy) break;
            chk("hold_valid", 32'(cur_ov(sel)), 1);
            chk("hold_quotient", cur_q(sel), eq);
            chk("hold_remainder", cur_r(sel), er);
            chk("hold_in_ready", 32'(cur_ir(sel)), 0);
        end
        drive(sel, 1'b0, 0, 0, 1'b0);
        set_ready(sel, 1'b0);
        chk("handshake_drop", 32'(cur_ov(sel)), 0);
        chk("in_ready_back", 32'(cur_ir(sel)), 1);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        sm;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(8, 1'b0, 0, 0, 1'b0);
        drive(16, 1'b0, 0, 0, 1'b0);
        or8  = 1'b0;
        or16 = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(ov8), 0);
        chk("rst_quotient", 32'(q8), 0);
        chk("rst_remainder", 32'(r8), 0);
        chk("rst_dbz", 32'(z8), 0);
        chk("rst_in_ready", 32'(ir8), 0);
        chk("rst_in_ready16", 32'(ir16), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready_low", 32'(ir8), 0);
        @(negedge clk);
        chk("post_rst_in_ready_high", 32'(ir8), 1);

        run_op(8, 200, 7, 1'b0, 0, 1'b0);
        run_op(8, 13, 0, 1'b0, 0, 1'b0);
        run_op(8, 9, 3, 1'b0, 0, 1'b0);
        run_op(8, 255, 1, 1'b0, 20, 1'b0);
        run_op(8, 5, 9, 1'b0, 0, 1'b0);
        run_op(8, 77, 5, 1'b0, 0, 1'b0);

        // Abort 100/3 during its fourth BUSY cycle.
        drive(8, 1'b1, 100, 3, 1'b0);
        repeat (4) @(negedge clk);
        drive(8, 1'b0, 0, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(ov8), 0);
        chk("abort_quotient", 32'(q8), 0);
        chk("abort_remainder", 32'(r8), 0);
        chk("abort_in_ready", 32'(ir8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready_low", 32'(ir8), 0);
        @(negedge clk);
        run_op(8, 100, 3, 1'b0, 0, 1'b0);

`ifdef DIVIDER_SEQ_SIGNED_EN
        run_op(8, 32'hF9, 2, 1'b1, 0, 1'b0);
        run_op(8, 32'h80, 32'hFF, 1'b1, 0, 1'b0);
        run_op(8, 7, 32'hFE, 1'b1, 0, 1'b0);
        run_op(8, 32'h85, 0, 1'b1, 0, 1'b0);
`endif

        for (int i = 0; i < 1500; i++) begin
            a = $urandom & 32'hFF;
            b = ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom & 32'hFF);
`ifdef DIVIDER_SEQ_SIGNED_EN
            sm = 1'($urandom);
`else
            sm = 1'b0;
`endif
            run_op(8, a, b, sm, 0, 1'b1);
        end
        for (int i = 0; i < 1200; i++) begin
            a = $urandom & 32'hFFFF;
            b = ($urandom_range(0, 15) == 0) ? 32'd0 :
                (($urandom_range(0, 1) == 0) ? ($urandom & 32'hFF) : ($urandom & 32'hFFFF));
`ifdef DIVIDER_SEQ_SIGNED_EN
            sm = 1'($urandom);
`else
            sm = 1'b0;
`endif
            run_op(16, a, b, sm, 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
